ram_fifo_ctrl: RTL

First-in, first-out (FIFO) controller that drives the single-port word RAM directly upstream of it: it owns the RAM's `rw`, `addr` and `data` inputs and consumes its `q` output. Upstream logic pushes words over a valid/ready handshake. Words are stored in the RAM and then prefetched into a 2-entry output buffer. Downstream logic pops them in order over a second valid/ready handshake.

---
 rtl/ram_fifo_ctrl.sv | 123 ++++++++++++
 1 files changed

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller that stores words in an external single-port RAM and
// prefetches them into a 2-entry output buffer, with reads taking priority.
module ram_fifo_ctrl #(
    parameter int DEPTH = 5,
    parameter int AW    = 5,
    parameter int DW    = 3
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [DW-1:0] in_data_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [DW-1:0] out_data_o,
    output logic [3:0]    level_o,
    output logic          ram_rw_o,
    output logic [AW-1:0] ram_addr_o,
    output logic [DW-1:0] ram_data_o,
    input  logic [DW-1:0] ram_q_i
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] MEM_FULL = CW'(DEPTH);
    localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] mem_cnt_q, mem_cnt_d;
    logic          inflight_q, inflight_d;
    logic [1:0]    ob_cnt_q, ob_cnt_d;
    logic [DW-1:0] ob_head_q, ob_head_d;
    logic [DW-1:0] ob_tail_q, ob_tail_d;

    logic          rd_req;
    logic          wr_en;
    logic          mem_not_full;
    logic          ob_push;
    logic          ob_pop;
    logic [2:0]    ob_pending;

    // A read is only issued when the buffer can absorb it, counting the word already in flight.
    assign ob_pending   = {1'b0, ob_cnt_q} + {2'b00, inflight_q};
    assign rd_req       = (mem_cnt_q != '0) && (ob_pending < 3'd2);
    assign mem_not_full = (mem_cnt_q < MEM_FULL);
    assign in_ready_o   = rst_ni && !rd_req && mem_not_full;
    assign wr_en        = in_valid_i && in_ready_o;
    assign ob_push      = inflight_q;
    assign ob_pop       = (ob_cnt_q != 2'd0) && out_ready_i;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        mem_cnt_d  = mem_cnt_q;
        inflight_d = rd_req;
        if (rd_req) begin
            rd_ptr_d  = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + AW'(1);
            mem_cnt_d = mem_cnt_q - CW'(1);
        end else if (wr_en) begin
            wr_ptr_d  = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + AW'(1);
            mem_cnt_d = mem_cnt_q + CW'(1);
        end
    end

    always_comb begin
        ob_head_d = ob_head_q;
        ob_tail_d = ob_tail_q;
        ob_cnt_d  = ob_cnt_q;
        unique case ({ob_push, ob_pop})
            2'b10: begin
                if (ob_cnt_q == 2'd0) begin
                    ob_head_d = ram_q_i;
                end else begin
                    ob_tail_d = ram_q_i;
                end
                ob_cnt_d = ob_cnt_q + 2'd1;
            end
            2'b01: begin
                ob_head_d = ob_tail_q;
                ob_cnt_d  = ob_cnt_q - 2'd1;
            end
            2'b11: begin
                // Simultaneous push and pop: the incoming word lands behind whatever stays.
                if (ob_cnt_q == 2'd1) begin
                    ob_head_d = ram_q_i;
                end else begin
                    ob_head_d = ob_tail_q;
                    ob_tail_d = ram_q_i;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            mem_cnt_q  <= '0;
            inflight_q <= 1'b0;
            ob_cnt_q   <= 2'd0;
            ob_head_q  <= '0;
            ob_tail_q  <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            mem_cnt_q  <= mem_cnt_d;
            inflight_q <= inflight_d;
            ob_cnt_q   <= ob_cnt_d;
            ob_head_q  <= ob_head_d;
            ob_tail_q  <= ob_tail_d;
        end
    end

    assign out_valid_o = (ob_cnt_q != 2'd0);
    assign out_data_o  = ob_head_q;
    assign level_o     = 4'(mem_cnt_q) + 4'(inflight_q) + 4'(ob_cnt_q);
    assign ram_rw_o    = wr_en;
    assign ram_addr_o  = wr_en ? wr_ptr_q : rd_ptr_q;
    assign ram_data_o  = in_data_i;

endmodule
